// File: rtl/axi4l_dpram.sv
// axi4l_dpram: parametrised AXI4-Lite slave RAM with one-entry AW/W holding registers and read-first RAM.
// Define AXI4L_DPRAM_SLVERR_EN to answer accesses at or above `size` with SLVERR instead of aliasing.
module axi4l_dpram #(
  parameter int size       = 'h1000,
  parameter int data_width = 32,
  parameter int addr_width = 32
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [addr_width-1:0]     awaddr,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [data_width-1:0]     wdata,
  input  logic [data_width/8-1:0]   wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [addr_width-1:0]     araddr,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [data_width-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready
);
  localparam int StrbW = data_width / 8;
  localparam int OffW  = $clog2(StrbW);
  localparam int SizeW = $clog2(size);
  localparam int IdxW  = SizeW - OffW;
  localparam int Depth = size / StrbW;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef logic [IdxW-1:0] idx_t;

  logic [data_width-1:0] mem [Depth];

  logic                  aw_held_q, w_held_q, aw_err_q;
  idx_t                  aw_idx_q;
  logic [data_width-1:0] w_data_q;
  logic [StrbW-1:0]      w_strb_q;
  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [data_width-1:0] rdata_q;

  logic aw_hs, w_hs, ar_hs, commit;
  logic aw_err, ar_err;
  idx_t aw_idx, ar_idx;
  logic unused_addr;

  assign aw_idx = awaddr[SizeW-1:OffW];
  assign ar_idx = araddr[SizeW-1:OffW];
  assign unused_addr = ^{awaddr, araddr};

`ifdef AXI4L_DPRAM_SLVERR_EN
  assign aw_err = {1'b0, awaddr} >= (addr_width+1)'(size);
  assign ar_err = {1'b0, araddr} >= (addr_width+1)'(size);
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif

  assign awready = !aw_held_q;
  assign wready  = !w_held_q;
  assign arready = !rvalid_q || rready;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign rvalid  = rvalid_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign ar_hs  = arvalid && arready;
  // A commit waits until the B slot is free or being drained this cycle.
  assign commit = aw_held_q && w_held_q && (!bvalid_q || bready);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      aw_err_q  <= 1'b0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      rvalid_q  <= 1'b0;
      rresp_q   <= RespOkay;
    end else begin
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_idx_q  <= aw_idx;
        aw_err_q  <= aw_err;
      end else if (commit) begin
        aw_held_q <= 1'b0;
      end

      if (w_hs) begin
        w_held_q <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end else if (commit) begin
        w_held_q <= 1'b0;
      end

      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= aw_err_q ? RespSlvErr : RespOkay;
      end else if (bready) begin
        bvalid_q <= 1'b0;
      end

      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rresp_q  <= ar_err ? RespSlvErr : RespOkay;
      end else if (rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // NOTE: the array and its read register carry no reset so they can map onto block RAM;
  // the non-blocking write lands after the same-edge read, giving read-first on a collision.
  always_ff @(posedge aclk) begin
    if (ar_hs) rdata_q <= ar_err ? '0 : mem[ar_idx];
    if (commit && !aw_err_q) begin
      for (int b = 0; b < StrbW; b++) begin
        if (w_strb_q[b]) mem[aw_idx_q][8*b +: 8] <= w_data_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi4l_dpram.sv
// tb_axi4l_dpram: directed and randomised checks of axi4l_dpram against a word-array reference model.
// Expectations follow AXI4L_DPRAM_SLVERR_EN when the bench is compiled with it.
module tb_axi4l_dpram;
  localparam int SIZE  = 'h1000;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int SW    = DW / 8;
  localparam int WORDS = SIZE / SW;

  logic          aclk = 1'b0, aresetn = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic          awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b1, rready = 1'b1;
  logic [DW-1:0] wdata = '0;
  logic [SW-1:0] wstrb = '0;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [DW-1:0] rdata;

  axi4l_dpram #(.size(SIZE), .data_width(DW), .addr_width(AW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  int pass_cnt = 0, total_cnt = 0;

  logic [DW-1:0] mem_m [WORDS];
  bit            known [WORDS];

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [SW-1:0] s);
    logic [DW-1:0] r = old;
    for (int b = 0; b < SW; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic int widx(input logic [AW-1:0] a);
    return int'((a % SIZE) / SW);
  endfunction

  function automatic logic [1:0] exp_resp(input logic [AW-1:0] a);
`ifdef AXI4L_DPRAM_SLVERR_EN
    return (a < SIZE) ? 2'b00 : 2'b10;
`else
    return 2'b00;
`endif
  endfunction

  function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] a);
    return (exp_resp(a) == 2'b00) ? mem_m[widx(a)] : '0;
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    if (exp_resp(a) == 2'b00) begin
      mem_m[widx(a)] = merge(mem_m[widx(a)], d, s);
      if (s == '1) known[widx(a)] = 1'b1;
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                          input int aw_dly, input int w_dly, input bit rnd, output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, b_done = 0, aw_go, w_go, b_go;
    int n = 0;
    resp = 2'b11;
    while (!b_done && n < 100) begin
      awaddr = a; wdata = d; wstrb = s;
      awvalid = !aw_done && n >= aw_dly;
      wvalid  = !w_done && n >= w_dly;
      bready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      b_go  = bvalid && bready;
      if (b_go) resp = bresp;
      tick();
      n++;
      if (aw_go) aw_done = 1;
      if (w_go) w_done = 1;
      if (b_go) b_done = 1;
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    total_cnt++;
    if (!b_done) $display("FAIL write_timeout: addr %h got no response within %0d cycles", a, n);
    else pass_cnt++;
    model_write(a, d, s);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input bit rnd, output logic [DW-1:0] d,
                         output logic [1:0] resp);
    bit ar_done = 0, r_done = 0, ar_go, r_go;
    int n = 0;
    d = '0; resp = 2'b11;
    while (!r_done && n < 100) begin
      araddr  = a;
      arvalid = !ar_done;
      rready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      ar_go = arvalid && arready;
      r_go  = rvalid && rready && ar_done;
      if (r_go) begin d = rdata; resp = rresp; end
      tick();
      n++;
      if (ar_go) ar_done = 1;
      if (r_go) r_done = 1;
    end
    arvalid = 1'b0; rready = 1'b1;
    total_cnt++;
    if (!r_done) $display("FAIL read_timeout: addr %h got no data within %0d cycles", a, n);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    tick(); tick();
    total_cnt++;
    if ({awready, wready, arready, bvalid, rvalid, bresp, rresp} !== 9'b111_00_0000)
      $display("FAIL reset_state: got %b expected %b",
               {awready, wready, arready, bvalid, rvalid, bresp, rresp}, 9'b111_00_0000);
    else pass_cnt++;
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    awaddr = 'h10; awvalid = 1'b1; wdata = 'hDEADBEEF; wstrb = 'hF; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    total_cnt++;
    if ({awready, wready, bvalid} !== 3'b000)
      $display("FAIL lat_held: aw/w ready,bvalid got %b expected 000", {awready, wready, bvalid});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({bvalid, bresp} !== 3'b100) $display("FAIL lat_bvalid: got %b expected 100", {bvalid, bresp});
    else pass_cnt++;
    model_write('h10, 'hDEADBEEF, 'hF);
    tick();
    total_cnt++;
    if (bvalid !== 1'b0) $display("FAIL lat_bdrop: bvalid got %b expected 0", bvalid);
    else pass_cnt++;
    araddr = 'h10; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    total_cnt++;
    if ({rvalid, rresp} !== 3'b100 || rdata !== exp_rdata('h10))
      $display("FAIL lat_read: rvalid,rresp %b rdata %h expected 100 %h", {rvalid, rresp}, rdata,
               exp_rdata('h10));
    else pass_cnt++;
    tick();
  endtask

  task automatic test_w_before_aw();
    logic [DW-1:0] d;
    logic [1:0]    resp;
    wdata = 'h11223344; wstrb = 'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    total_cnt++;
    if ({awready, wready} !== 2'b10) $display("FAIL wfirst_ready: got %b expected 10", {awready, wready});
    else pass_cnt++;
    tick(); tick();
    total_cnt++;
    if ({bvalid, wready} !== 2'b00) $display("FAIL wfirst_wait: bvalid,wready got %b expected 00", {bvalid, wready});
    else pass_cnt++;
    awaddr = 'h20; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    total_cnt++;
    if ({awready, wready} !== 2'b00) $display("FAIL wfirst_held: got %b expected 00", {awready, wready});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({bvalid, bresp} !== 3'b100) $display("FAIL wfirst_b: got %b expected 100", {bvalid, bresp});
    else pass_cnt++;
    model_write('h20, 'h11223344, 'hF);
    tick();
    do_write('h20, 'h0000AA00, 'h2, 0, 0, 0, resp);
    do_read('h20, 0, d, resp);
    total_cnt++;
    if (d !== 32'h1122AA44 || d !== mem_m[8]) $display("FAIL strobe_merge: got %h expected %h", d, 32'h1122AA44);
    else pass_cnt++;
  endtask

  task automatic test_b_backpressure();
    logic [DW-1:0] d1 = $urandom, d2 = $urandom, d;
    logic [1:0]    resp;
    bready = 1'b0;
    awaddr = 'h40; awvalid = 1'b1; wdata = d1; wstrb = 'hF; wvalid = 1'b1;
    tick();
    awaddr = 'h44; wdata = d2;
    tick();
    total_cnt++;
    if (bvalid !== 1'b1) $display("FAIL bp_first_b: bvalid got %b expected 1", bvalid);
    else pass_cnt++;
    model_write('h40, d1, 'hF);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if ({bvalid, awready, wready} !== 3'b100)
        $display("FAIL bp_stall%0d: bvalid,awready,wready got %b expected 100", i, {bvalid, awready, wready});
      else pass_cnt++;
      tick();
    end
    bready = 1'b1;
    tick();
    total_cnt++;
    if ({bvalid, bresp} !== 3'b100) $display("FAIL bp_second_b: got %b expected 100", {bvalid, bresp});
    else pass_cnt++;
    model_write('h44, d2, 'hF);
    tick();
    total_cnt++;
    if (bvalid !== 1'b0) $display("FAIL bp_drain: bvalid got %b expected 0", bvalid);
    else pass_cnt++;
    do_read('h40, 0, d, resp);
    total_cnt++;
    if (d !== mem_m[16]) $display("FAIL bp_data1: got %h expected %h", d, mem_m[16]);
    else pass_cnt++;
    do_read('h44, 0, d, resp);
    total_cnt++;
    if (d !== mem_m[17]) $display("FAIL bp_data2: got %h expected %h", d, mem_m[17]);
    else pass_cnt++;
  endtask

  task automatic test_r_backpressure();
    logic [1:0] resp;
    do_write('h0, $urandom, 'hF, 0, 0, 0, resp);
    do_write('h4, $urandom, 'hF, 0, 0, 0, resp);
    rready = 1'b0; araddr = 'h0; arvalid = 1'b1;
    #1;
    total_cnt++;
    if (arready !== 1'b1) $display("FAIL rbp_arready: got %b expected 1", arready);
    else pass_cnt++;
    tick();
    araddr = 'h4;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if ({rvalid, arready} !== 2'b10 || rdata !== mem_m[0])
        $display("FAIL rbp_stall%0d: rvalid,arready %b rdata %h expected 10 %h", i, {rvalid, arready}, rdata, mem_m[0]);
      else pass_cnt++;
      tick();
    end
    rready = 1'b1;
    tick();
    arvalid = 1'b0;
    total_cnt++;
    if (rvalid !== 1'b1 || rdata !== mem_m[1])
      $display("FAIL rbp_word1: rvalid %b rdata %h expected 1 %h", rvalid, rdata, mem_m[1]);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (rvalid !== 1'b0) $display("FAIL rbp_drain: rvalid got %b expected 0", rvalid);
    else pass_cnt++;
  endtask

  task automatic test_collision();
    logic [DW-1:0] old_v;
    logic [1:0]    resp;
    do_write('h20, 'h0, 'hF, 0, 0, 0, resp);
    old_v = mem_m[8];
    awaddr = 'h20; awvalid = 1'b1; wdata = 'h55; wstrb = 'hF; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 'h20; arvalid = 1'b1; rready = 1'b1;
    tick();
    total_cnt++;
    if ({bvalid, rvalid} !== 2'b11 || rdata !== old_v)
      $display("FAIL coll_old: bvalid,rvalid %b rdata %h expected 11 %h", {bvalid, rvalid}, rdata, old_v);
    else pass_cnt++;
    model_write('h20, 'h55, 'hF);
    tick();
    arvalid = 1'b0;
    total_cnt++;
    if (rvalid !== 1'b1 || rdata !== mem_m[8])
      $display("FAIL coll_new: rvalid %b rdata %h expected 1 %h", rvalid, rdata, mem_m[8]);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_out_of_range();
    logic [DW-1:0] d;
    logic [1:0]    resp;
    do_write('h0, 'hCAFE0001, 'hF, 0, 0, 0, resp);
    do_write('h1000, 'h5A5A1234, 'hF, 1, 0, 0, resp);
    total_cnt++;
    if (resp !== exp_resp('h1000)) $display("FAIL oor_bresp: got %b expected %b", resp, exp_resp('h1000));
    else pass_cnt++;
    do_read('h1000, 0, d, resp);
    total_cnt++;
    if (resp !== exp_resp('h1000) || d !== exp_rdata('h1000))
      $display("FAIL oor_read: rresp %b rdata %h expected %b %h", resp, d, exp_resp('h1000), exp_rdata('h1000));
    else pass_cnt++;
    do_read('h0, 0, d, resp);
    total_cnt++;
    if (d !== mem_m[0] || resp !== 2'b00)
      $display("FAIL oor_word0: rdata %h rresp %b expected %h 00", d, resp, mem_m[0]);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [AW-1:0] a;
    logic [1:0]    resp;
    int            w;
    for (int i = 0; i < 80; i++) begin
      w = $urandom_range(0, 15);
      a = AW'(w * SW + $urandom_range(0, SW - 1));
      if ($urandom_range(0, 1) == 1 || !known[w]) begin
        s = known[w] ? SW'($urandom) : '1;
        d = $urandom;
        do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), 1, resp);
        total_cnt++;
        if (resp !== 2'b00) $display("FAIL rnd_bresp%0d: addr %h got %b expected 00", i, a, resp);
        else pass_cnt++;
      end else begin
        do_read(a, 1, d, resp);
        total_cnt++;
        if (d !== mem_m[w] || resp !== 2'b00)
          $display("FAIL rnd_read%0d: addr %h rdata %h rresp %b expected %h 00", i, a, d, resp, mem_m[w]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d1 = $urandom, d2 = $urandom, d;
    logic [1:0]    resp;
    do_write('h14, $urandom, 'hF, 0, 0, 0, resp);
    rready = 1'b0; araddr = 'h14; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    bready = 1'b0; awaddr = 'h14; wdata = d1; wstrb = 'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    wdata = d2;
    tick();
    model_write('h14, d1, 'hF);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    total_cnt++;
    if ({bvalid, rvalid, awready, wready} !== 4'b1100)
      $display("FAIL rst_pre: bvalid,rvalid,awready,wready got %b expected 1100", {bvalid, rvalid, awready, wready});
    else pass_cnt++;
    #2 aresetn = 1'b0;
    #1;
    total_cnt++;
    if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111)
      $display("FAIL rst_async: got %b expected 00111", {bvalid, rvalid, awready, wready, arready});
    else pass_cnt++;
    tick(); tick();
    aresetn = 1'b1; rready = 1'b1; bready = 1'b1;
    tick(); tick();
    total_cnt++;
    if ({bvalid, rvalid} !== 2'b00) $display("FAIL rst_after: bvalid,rvalid got %b expected 00", {bvalid, rvalid});
    else pass_cnt++;
    do_read('h14, 0, d, resp);
    total_cnt++;
    if (d !== mem_m[5]) $display("FAIL rst_ram: got %h expected %h", d, mem_m[5]);
    else pass_cnt++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency();
    test_w_before_aw();
    test_b_backpressure();
    test_r_backpressure();
    test_collision();
    test_out_of_range();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
